// File: rtl/hbm_port_arbiter_if.sv
// Bundle of every requester-side and HBM-side signal of hbm_port_arbiter.
//   slave  : arbiter view (takes start pulses and HBM completions, drives the rest)
//   master : environment view (MPU array plus HBM controller)
// Requester i occupies slice [i*AddrWidth +: AddrWidth] of the address vectors
// and [i*DataWidth +: DataWidth] of req_write_data.
interface hbm_port_arbiter_if #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned ReqIdWidth = 2,
  parameter int unsigned AddrWidth  = 33,
  parameter int unsigned DataWidth  = 256
);
  logic [NumReq-1:0]           req_start_rd;
  logic [NumReq-1:0]           req_start_wr;
  logic [NumReq*AddrWidth-1:0] req_read_addr;
  logic [NumReq*AddrWidth-1:0] req_write_addr;
  logic [NumReq*DataWidth-1:0] req_write_data;
  logic [NumReq-1:0]           req_end_rd;
  logic [NumReq-1:0]           req_end_wr;
  logic [DataWidth-1:0]        req_read_data;
  logic                        mem_start_rd;
  logic                        mem_start_wr;
  logic [AddrWidth-1:0]        mem_read_addr;
  logic [AddrWidth-1:0]        mem_write_addr;
  logic [DataWidth-1:0]        mem_write_data;
  logic [DataWidth-1:0]        mem_read_data;
  logic                        mem_end_rd;
  logic                        mem_end_wr;
  logic [ReqIdWidth-1:0]       grant_id;
  logic                        busy;
  logic                        err_overrun;

  modport slave (
    input  req_start_rd, req_start_wr, req_read_addr, req_write_addr, req_write_data,
           mem_read_data, mem_end_rd, mem_end_wr,
    output req_end_rd, req_end_wr, req_read_data, mem_start_rd, mem_start_wr,
           mem_read_addr, mem_write_addr, mem_write_data, grant_id, busy, err_overrun
  );

  modport master (
    output req_start_rd, req_start_wr, req_read_addr, req_write_addr, req_write_data,
           mem_read_data, mem_end_rd, mem_end_wr,
    input  req_end_rd, req_end_wr, req_read_data, mem_start_rd, mem_start_wr,
           mem_read_addr, mem_write_addr, mem_write_data, grant_id, busy, err_overrun
  );
endinterface

// File: rtl/hbm_port_arbiter.sv
// Round-robin arbiter sharing one HBM read/write port among NumReq requesters.
// Start pulses are latched into per-requester pending bits and address/data
// slots; one memory transaction runs at a time (IDLE -> ISSUE -> WAIT).
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : hbm_port_arbiter_if.slave (requester handshakes, HBM port, status)
module hbm_port_arbiter #(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned ReqIdWidth = 2,
  parameter int unsigned AddrWidth  = 33,
  parameter int unsigned DataWidth  = 256
) (
  input logic               clk,
  input logic               resetn,
  hbm_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                r_state, w_state_d;
  logic [NumReq-1:0]     r_pend_rd, r_pend_wr;
  logic [AddrWidth-1:0]  r_rd_addr [NumReq];
  logic [AddrWidth-1:0]  r_wr_addr [NumReq];
  logic [DataWidth-1:0]  r_wr_data [NumReq];
  logic [ReqIdWidth-1:0] r_rr_ptr, r_grant;
  logic                  r_op_rd;
  logic [AddrWidth-1:0]  r_mem_rd_addr, r_mem_wr_addr;
  logic [DataWidth-1:0]  r_mem_wr_data, r_rd_data;
  logic [NumReq-1:0]     r_end_rd, r_end_wr;
  logic                  r_err;

  logic [NumReq-1:0]     w_pend_any, w_grant_oh;
  logic [NumReq-1:0]     w_clr_rd, w_clr_wr, w_set_rd, w_set_wr;
  logic [ReqIdWidth-1:0] w_pick, w_idx;
  logic                  w_found, w_grant, w_complete, w_end_hit, w_overrun, w_end_busy;

  assign w_pend_any = r_pend_rd | r_pend_wr;
  assign w_grant_oh = NumReq'(1) << r_grant;
  assign w_end_hit  = r_op_rd ? bus.mem_end_rd : bus.mem_end_wr;
  // Hold off the next grant while a completion pulse is out, so the next
  // issue lands no earlier than three cycles after the HBM end pulse.
  assign w_end_busy = (|r_end_rd) | (|r_end_wr);

  // First requester with any pending op, searching upward from r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      w_idx = ReqIdWidth'((32'(r_rr_ptr) + k) % NumReq);
      if (!w_found && w_pend_any[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_grant    = 1'b0;
    w_complete = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_found && !w_end_busy) begin
          w_grant   = 1'b1;
          w_state_d = StIssue;
        end
      end
      StIssue, StWait: begin
        if (w_end_hit) begin
          w_complete = 1'b1;
          w_state_d  = StIdle;
        end else begin
          w_state_d = StWait;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_clr_rd = (w_complete && r_op_rd)  ? w_grant_oh : '0;
  assign w_clr_wr = (w_complete && !r_op_rd) ? w_grant_oh : '0;
  // A pulse is accepted when its bit is free or being cleared this cycle.
  assign w_set_rd = bus.req_start_rd & (~r_pend_rd | w_clr_rd);
  assign w_set_wr = bus.req_start_wr & (~r_pend_wr | w_clr_wr);
  assign w_overrun = (|(bus.req_start_rd & r_pend_rd & ~w_clr_rd)) |
                     (|(bus.req_start_wr & r_pend_wr & ~w_clr_wr));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Pending bits and per-requester slots.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend_rd <= '0;
      r_pend_wr <= '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
        r_rd_addr[i] <= '0;
        r_wr_addr[i] <= '0;
        r_wr_data[i] <= '0;
      end
    end else begin
      r_pend_rd <= (r_pend_rd & ~w_clr_rd) | w_set_rd;
      r_pend_wr <= (r_pend_wr & ~w_clr_wr) | w_set_wr;
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (w_set_rd[i]) r_rd_addr[i] <= bus.req_read_addr[i*AddrWidth +: AddrWidth];
        if (w_set_wr[i]) begin
          r_wr_addr[i] <= bus.req_write_addr[i*AddrWidth +: AddrWidth];
          r_wr_data[i] <= bus.req_write_data[i*DataWidth +: DataWidth];
        end
      end
    end
  end

  // Grant, memory-side latches, completion routing and status.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_op_rd       <= 1'b0;
      r_mem_rd_addr <= '0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
      r_rd_data     <= '0;
      r_end_rd      <= '0;
      r_end_wr      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_end_rd <= w_clr_rd;
      r_end_wr <= w_clr_wr;
      r_err    <= r_err | w_overrun;
      if (w_grant) begin
        r_grant       <= w_pick;
        r_op_rd       <= r_pend_rd[w_pick];  // read wins when both are pending
        r_mem_rd_addr <= r_rd_addr[w_pick];
        r_mem_wr_addr <= r_wr_addr[w_pick];
        r_mem_wr_data <= r_wr_data[w_pick];
      end
      if (w_complete) begin
        r_rr_ptr <= (r_grant == ReqIdWidth'(NumReq - 1)) ? '0 : r_grant + ReqIdWidth'(1);
        if (r_op_rd) r_rd_data <= bus.mem_read_data;
      end
    end
  end

  assign bus.req_end_rd     = r_end_rd;
  assign bus.req_end_wr     = r_end_wr;
  assign bus.req_read_data  = r_rd_data;
  assign bus.mem_start_rd   = (r_state == StIssue) && r_op_rd;
  assign bus.mem_start_wr   = (r_state == StIssue) && !r_op_rd;
  assign bus.mem_read_addr  = r_mem_rd_addr;
  assign bus.mem_write_addr = r_mem_wr_addr;
  assign bus.mem_write_data = r_mem_wr_data;
  assign bus.grant_id       = r_grant;
  assign bus.busy           = (r_state != StIdle);
  assign bus.err_overrun    = r_err;

endmodule
